kart_motion_sequencer: RTL

- Per-frame scheduler that time-shares one sin/cos lookup ROM pair (11-bit signed, scale 512, 360 entries, registered-output) between NUM_KARTS karts.
- On each frame strobe it snapshots every kart's heading and the speed, then walks the karts in index order. For each kart it issues the ROM address, waits out the ROM latency and computes signed per-frame position increments dx/dy.
- It replaces per-kart private trig ROMs. It sits between the kart state registers and the position-update logic.

---
 rtl/kart_motion_sequencer_if.sv | 38 +++
 rtl/kart_motion_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kart_motion_sequencer_if.sv
// ============================================================================
// Module      : kart_motion_sequencer_if
// Description : Frame-strobe, kart-state, shared trig ROM and dx/dy result
//               bundle for kart_motion_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kart_motion_sequencer_if #(
  parameter int NUM_KARTS = 2
);
  logic                      frame_start;
  logic [9*NUM_KARTS-1:0]    dir_in;
  logic [10:0]               speed_in;
  logic [8:0]                rom_addr;
  logic signed [10:0]        rom_cos;
  logic signed [10:0]        rom_sin;
  logic [12*NUM_KARTS-1:0]   dx_out;
  logic [12*NUM_KARTS-1:0]   dy_out;
  logic                      busy;
  logic                      done;
  logic                      dir_err;
  logic                      overrun;

  // Environment side: kart state, frame strobe and the ROM data.
  modport master (
    output frame_start, dir_in, speed_in, rom_cos, rom_sin,
    input  rom_addr, dx_out, dy_out, busy, done, dir_err, overrun
  );

  // Sequencer side.
  modport slave (
    input  frame_start, dir_in, speed_in, rom_cos, rom_sin,
    output rom_addr, dx_out, dy_out, busy, done, dir_err, overrun
  );
endinterface

`default_nettype wire

// File: rtl/kart_motion_sequencer.sv
// ============================================================================
// Module      : kart_motion_sequencer
// Description : Per-frame scheduler sharing one sin/cos ROM pair between karts,
//               producing saturated signed dx/dy increments per kart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kart_motion_sequencer #(
  parameter int NUM_KARTS   = 2,
  parameter int ROM_LATENCY = 2,
  parameter int FRAC_SHIFT  = 9
) (
  input wire clk,
  input wire rst,
  kart_motion_sequencer_if.slave bus
);

  localparam int KW = (NUM_KARTS > 1) ? $clog2(NUM_KARTS) : 1;
  localparam int CW = $clog2(ROM_LATENCY + 2);
  localparam int PW = 23;

  localparam logic [KW-1:0]          LAST_K   = KW'(NUM_KARTS - 1);
  localparam logic [CW-1:0]          CNT_LOAD = CW'(ROM_LATENCY);
  localparam logic signed [PW-1:0]   BIAS     = PW'((1 << FRAC_SHIFT) - 1);
  localparam logic signed [PW-1:0]   SAT_MAX  = 23'sd2047;
  localparam logic signed [PW-1:0]   SAT_MIN  = -23'sd2048;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q;
  logic [CW-1:0]            cnt_q;
  logic [9*NUM_KARTS-1:0]   dir_snap_q;
  logic [10:0]              speed_q;
  logic [8:0]               rom_addr_q;
  logic [12*NUM_KARTS-1:0]  shadow_dx_q;
  logic [12*NUM_KARTS-1:0]  shadow_dy_q;
  logic [12*NUM_KARTS-1:0]  dx_out_q;
  logic [12*NUM_KARTS-1:0]  dy_out_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     dir_err_q;
  logic                     overrun_q;

  // Division by 2**FRAC_SHIFT rounding toward zero: bias negatives before the shift.
  function automatic logic signed [PW-1:0] div_trunc(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] biased;
    biased = p[PW-1] ? (p + BIAS) : p;
    return biased >>> FRAC_SHIFT;
  endfunction

  function automatic logic signed [11:0] sat12(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) begin
      return 12'sh7FF;
    end else if (v < SAT_MIN) begin
      return 12'sh800;
    end else begin
      return v[11:0];
    end
  endfunction

  logic [8:0]              w_dir_k;
  logic                    w_dir_bad;
  logic signed [PW-1:0]    w_spd_ext;
  logic signed [PW-1:0]    w_cos_ext;
  logic signed [PW-1:0]    w_sin_ext;
  logic signed [PW-1:0]    w_px;
  logic signed [PW-1:0]    w_py;
  logic signed [PW-1:0]    w_qx;
  logic signed [PW-1:0]    w_qy;
  logic signed [11:0]      w_dx;
  logic signed [11:0]      w_dy;

  assign w_dir_k   = dir_snap_q[9*k_q +: 9];
  assign w_dir_bad = (w_dir_k >= 9'd360);

  assign w_spd_ext = {{(PW-11){1'b0}}, speed_q};
  assign w_cos_ext = {{(PW-11){bus.rom_cos[10]}}, bus.rom_cos};
  assign w_sin_ext = {{(PW-11){bus.rom_sin[10]}}, bus.rom_sin};
  assign w_px      = w_spd_ext * w_cos_ext;
  assign w_py      = w_spd_ext * w_sin_ext;
  assign w_qx      = div_trunc(w_px);
  assign w_qy      = div_trunc(w_py);
  // Screen y grows downward, so a positive sine moves the kart up.
  assign w_dx      = sat12(w_qx);
  assign w_dy      = sat12(-w_qy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.frame_start) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (cnt_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = (k_q == LAST_K) ? S_COMMIT : S_ISSUE;
      S_COMMIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      cnt_q       <= '0;
      dir_snap_q  <= '0;
      speed_q     <= '0;
      rom_addr_q  <= '0;
      shadow_dx_q <= '0;
      shadow_dy_q <= '0;
      dx_out_q    <= '0;
      dy_out_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dir_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Any strobe outside IDLE, including the COMMIT edge, is dropped.
      if (bus.frame_start && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.frame_start) begin
            dir_snap_q <= bus.dir_in;
            speed_q    <= bus.speed_in;
            busy_q     <= 1'b1;
            k_q        <= '0;
          end
        end
        S_ISSUE: begin
          rom_addr_q <= w_dir_bad ? 9'd0 : w_dir_k;
          if (w_dir_bad) begin
            dir_err_q <= 1'b1;
          end
          cnt_q <= CNT_LOAD;
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CAPTURE: begin
          shadow_dx_q[12*k_q +: 12] <= w_dx;
          shadow_dy_q[12*k_q +: 12] <= w_dy;
          if (k_q != LAST_K) begin
            k_q <= k_q + 1'b1;
          end
        end
        S_COMMIT: begin
          dx_out_q <= shadow_dx_q;
          dy_out_q <= shadow_dy_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.dx_out   = dx_out_q;
  assign bus.dy_out   = dy_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dir_err  = dir_err_q;
  assign bus.overrun  = overrun_q;

endmodule

`default_nettype wire
